// File: rtl/memadapt_pkg.sv
// Shared definitions for wb_mem_adapter: FSM encoding, lane helper and latency limit.
package memadapt_pkg;

    localparam int unsigned MAX_RD_LAT = 3;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRwait,
        StAck,
        StHold
    } state_e;

    function automatic int unsigned lanes(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/wb_mem_adapter.sv
// Wishbone classic slave to synchronous single-port RAM/ROM primitive adapter.
// Define WB_MEM_ADAPTER_ERR_EN to report out-of-range and ROM-write accesses on wb_err_o.
module wb_mem_adapter
    import memadapt_pkg::*;
#(
    parameter int unsigned AW     = 11,
    parameter int unsigned DW     = 16,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned RD_LAT = 1,
    parameter bit          ROM    = 1'b0
) (
    input  logic                   wb_clk_i,
    input  logic                   rst_n,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [AW-1:0]          wb_adr_i,
    input  logic [lanes(DW)-1:0]   wb_sel_i,
    input  logic [DW-1:0]          wb_dat_i,
    output logic [DW-1:0]          wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_din,
    output logic [lanes(DW)-1:0]   mem_we,
    output logic                   mem_rden,
    input  logic [DW-1:0]          mem_dout
);

    localparam int unsigned    CntW     = $clog2(MAX_RD_LAT + 1);
    localparam int unsigned    NLanes   = lanes(DW);
    localparam logic [AW:0]    DepthLim = (AW + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_din_q, mem_din_d;
    logic [NLanes-1:0]   mem_we_q, mem_we_d;
    logic                mem_rden_q, mem_rden_d;
    logic [DW-1:0]       dat_q, dat_d;
    logic                ack_q, ack_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                rd_q, rd_d;
    logic                bad_q, bad_d;
    logic                oor;

    // Addresses at or beyond DEPTH are rejected rather than aliased.
    assign oor = {1'b0, wb_adr_i} >= DepthLim;

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = '0;
        mem_rden_d = 1'b0;
        dat_d      = dat_q;
        ack_d      = 1'b0;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        bad_d      = bad_q;
        unique case (state_q)
            StIdle: begin
                if (wb_cyc_i && wb_stb_i) begin
                    mem_addr_d = wb_adr_i;
                    rd_d       = !wb_we_i;
                    if (wb_we_i) begin
                        mem_din_d = wb_dat_i;
                        bad_d     = oor || ROM;
                        mem_we_d  = (oor || ROM) ? '0 : wb_sel_i;
                        state_d   = StWrite;
                    end else begin
                        bad_d      = oor;
                        mem_rden_d = !oor;
                        cnt_d      = CntW'(RD_LAT);
                        state_d    = StRwait;
                    end
                end
            end
            StWrite: begin
                state_d = wb_cyc_i ? StAck : StIdle;
            end
            StRwait: begin
                if (!wb_cyc_i) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    // Leave one clock early so capture and ack land together after RD_LAT+1.
                    if (cnt_q <= CntW'(1)) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
`ifdef WB_MEM_ADAPTER_ERR_EN
                if (rd_q && !bad_q) begin
                    dat_d = mem_dout;
                end
                ack_d = !bad_q;
`else
                if (rd_q) begin
                    dat_d = bad_q ? '0 : mem_dout;
                end
                ack_d = 1'b1;
`endif
                state_d = StHold;
            end
            StHold: begin
                if (!wb_stb_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= '0;
            mem_rden_q <= 1'b0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_q   <= mem_we_d;
            mem_rden_q <= mem_rden_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            bad_q      <= bad_d;
        end
    end

`ifdef WB_MEM_ADAPTER_ERR_EN
    logic err_q;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == StAck) && bad_q;
        end
    end

    assign wb_err_o = err_q;
`else
    assign wb_err_o = 1'b0;
`endif

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;
    assign mem_rden = mem_rden_q;

endmodule

// File: tb/tb_wb_mem_adapter.sv
// Bench for wb_mem_adapter: a RAM instance (DEPTH 1536, RD_LAT 2) and a ROM instance (RD_LAT 1).
module tb_wb_mem_adapter;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 16;
`ifdef WB_MEM_ADAPTER_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cyc, stb, we, tgt;
    logic [AW-1:0] adr;
    logic [1:0]    sel;
    logic [DW-1:0] dat_w;

    logic [DW-1:0] a_dat_o, a_din, a_dout, b_dat_o, b_din, b_dout;
    logic          a_ack, a_err, a_rden, b_ack, b_err, b_rden;
    logic [AW-1:0] a_addr, b_addr;
    logic [1:0]    a_we, b_we;

    wb_mem_adapter #(.AW(AW), .DW(DW), .DEPTH(1536), .RD_LAT(2), .ROM(1'b0)) u_ram (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .wb_cyc_i (cyc & ~tgt),
        .wb_stb_i (stb & ~tgt),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_sel_i (sel),
        .wb_dat_i (dat_w),
        .wb_dat_o (a_dat_o),
        .wb_ack_o (a_ack),
        .wb_err_o (a_err),
        .mem_addr (a_addr),
        .mem_din  (a_din),
        .mem_we   (a_we),
        .mem_rden (a_rden),
        .mem_dout (a_dout)
    );

    wb_mem_adapter #(.AW(AW), .DW(DW), .DEPTH(2048), .RD_LAT(1), .ROM(1'b1)) u_rom (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .wb_cyc_i (cyc & tgt),
        .wb_stb_i (stb & tgt),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_sel_i (sel),
        .wb_dat_i (dat_w),
        .wb_dat_o (b_dat_o),
        .wb_ack_o (b_ack),
        .wb_err_o (b_err),
        .mem_addr (b_addr),
        .mem_din  (b_din),
        .mem_we   (b_we),
        .mem_rden (b_rden),
        .mem_dout (b_dout)
    );

    // Primitive models: byte-lane writes, read data valid RD_LAT clocks after the rden edge.
    logic          mem_init;
    logic [DW-1:0] mem_a [2048];
    logic [DW-1:0] mem_b [2048];
    logic [DW-1:0] pipe_a0, pipe_a1, pipe_b0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            mem_b[0] <= 16'hBEEF;
            mem_b[1] <= 16'h1234;
            pipe_a0  <= '0;
            pipe_a1  <= '0;
            pipe_b0  <= '0;
        end else begin
            if (a_we[0]) mem_a[a_addr][7:0]  <= a_din[7:0];
            if (a_we[1]) mem_a[a_addr][15:8] <= a_din[15:8];
            if (b_we[0]) mem_b[b_addr][7:0]  <= b_din[7:0];
            if (b_we[1]) mem_b[b_addr][15:8] <= b_din[15:8];
            if (a_rden) pipe_a0 <= mem_a[a_addr];
            pipe_a1 <= pipe_a0;
            if (b_rden) pipe_b0 <= mem_b[b_addr];
        end
    end
    assign a_dout = pipe_a1;
    assign b_dout = pipe_b0;

    logic          mon_ack, mon_err, mon_rden;
    logic [1:0]    mon_we;
    logic [DW-1:0] mon_dat;
    assign mon_ack  = tgt ? b_ack   : a_ack;
    assign mon_err  = tgt ? b_err   : a_err;
    assign mon_rden = tgt ? b_rden  : a_rden;
    assign mon_we   = tgt ? b_we    : a_we;
    assign mon_dat  = tgt ? b_dat_o : a_dat_o;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus transaction; stb stays up for `hold` clocks after the ack, then 3 quiet clocks.
    task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [1:0] s,
                           input logic [DW-1:0] d, input int hold, output int lat,
                           output int we_n, output logic [1:0] we_v, output int rd_n,
                           output int ack_n, output int err_n);
        bit done;
        int extra;
        lat = -1; we_n = 0; we_v = '0; rd_n = 0; ack_n = 0; err_n = 0;
        done = 1'b0; extra = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (mon_we != 2'b00) begin we_n++; we_v = mon_we; end
            if (mon_rden) rd_n++;
            if (mon_ack) ack_n++;
            if (mon_err) err_n++;
            if ((mon_ack || mon_err) && !done) begin done = 1'b1; lat = n; end
            if (done) begin
                if (extra >= hold) break;
                extra++;
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (mon_we != 2'b00) we_n++;
            if (mon_rden) rd_n++;
            if (mon_ack) ack_n++;
            if (mon_err) err_n++;
        end
    endtask

    typedef struct {
        string         name;
        logic          t;
        logic          w;
        logic [AW-1:0] a;
        logic [1:0]    s;
        logic [DW-1:0] d;
        int            hold;
        int            lat;
        int            we_n;
        logic [1:0]    we_v;
        int            rd_n;
        logic          bad;
        logic [DW-1:0] rdat;
    } vec_t;

    function automatic vec_t mk(input string name, input logic t, input logic w,
                                input logic [AW-1:0] a, input logic [1:0] s,
                                input logic [DW-1:0] d, input int hold, input int lat,
                                input int we_n, input logic [1:0] we_v, input int rd_n,
                                input logic bad, input logic [DW-1:0] rdat);
        vec_t v;
        v.name = name; v.t = t; v.w = w; v.a = a; v.s = s; v.d = d; v.hold = hold;
        v.lat = lat; v.we_n = we_n; v.we_v = we_v; v.rd_n = rd_n; v.bad = bad; v.rdat = rdat;
        return v;
    endfunction

    vec_t vecs[12];

    initial begin : main
        int lat, we_n, rd_n, ack_n, err_n, stray;
        logic [1:0] we_v;
        int exp_ack, exp_err;

        vecs[0]  = mk("wr_a55a",    1'b0, 1'b1, 11'h010, 2'b11, 16'hA55A, 0, 2, 1, 2'b11, 0,
                      1'b0, 16'h0000);
        vecs[1]  = mk("rd_a55a",    1'b0, 1'b0, 11'h010, 2'b11, 16'h0000, 0, 3, 0, 2'b00, 1,
                      1'b0, 16'hA55A);
        vecs[2]  = mk("wr_lane_hi", 1'b0, 1'b1, 11'h010, 2'b10, 16'h12FF, 0, 2, 1, 2'b10, 0,
                      1'b0, 16'h0000);
        vecs[3]  = mk("rd_lane_hi", 1'b0, 1'b0, 11'h010, 2'b00, 16'h0000, 0, 3, 0, 2'b00, 1,
                      1'b0, 16'h125A);
        vecs[4]  = mk("wr_last",    1'b0, 1'b1, 11'h5FF, 2'b01, 16'h0F0F, 0, 2, 1, 2'b01, 0,
                      1'b0, 16'h0000);
        vecs[5]  = mk("rd_slow",    1'b0, 1'b0, 11'h5FF, 2'b11, 16'h0000, 4, 3, 0, 2'b00, 1,
                      1'b0, 16'h000F);
        vecs[6]  = mk("rd_oor",     1'b0, 1'b0, 11'h600, 2'b11, 16'h0000, 0, 3, 0, 2'b00, 0,
                      1'b1, ErrEn ? 16'h000F : 16'h0000);
        vecs[7]  = mk("wr_oor",     1'b0, 1'b1, 11'h7FF, 2'b11, 16'hBBBB, 0, 2, 0, 2'b00, 0,
                      1'b1, 16'h0000);
        vecs[8]  = mk("rd_again",   1'b0, 1'b0, 11'h010, 2'b01, 16'h0000, 0, 3, 0, 2'b00, 1,
                      1'b0, 16'h125A);
        vecs[9]  = mk("rom_wr",     1'b1, 1'b1, 11'h000, 2'b11, 16'hFFFF, 0, 2, 0, 2'b00, 0,
                      1'b1, 16'h0000);
        vecs[10] = mk("rom_rd0",    1'b1, 1'b0, 11'h000, 2'b11, 16'h0000, 0, 2, 0, 2'b00, 1,
                      1'b0, 16'hBEEF);
        vecs[11] = mk("rom_rd1",    1'b1, 1'b0, 11'h001, 2'b11, 16'h0000, 2, 2, 0, 2'b00, 1,
                      1'b0, 16'h1234);

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; tgt = 1'b0;
        adr = '0; sel = '0; dat_w = '0; mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("rst_ack",  int'(a_ack),   0);
        check("rst_dat",  int'(a_dat_o), 0);
        check("rst_we",   int'(a_we),    0);
        check("rst_rden", int'(a_rden),  0);
        check("rst_addr", int'(a_addr),  0);
        check("rst_err",  int'(b_err),   0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            tgt = vecs[i].t;
            run_txn(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].hold,
                    lat, we_n, we_v, rd_n, ack_n, err_n);
            exp_ack = (ErrEn && vecs[i].bad) ? 0 : 1;
            exp_err = (ErrEn && vecs[i].bad) ? 1 : 0;
            check({vecs[i].name, "_lat"},   lat,         vecs[i].lat);
            check({vecs[i].name, "_we_n"},  we_n,        vecs[i].we_n);
            check({vecs[i].name, "_we_v"},  int'(we_v),  int'(vecs[i].we_v));
            check({vecs[i].name, "_rden"},  rd_n,        vecs[i].rd_n);
            check({vecs[i].name, "_ack"},   ack_n,       exp_ack);
            check({vecs[i].name, "_err"},   err_n,       exp_err);
            if (!vecs[i].w) begin
                check({vecs[i].name, "_dat"}, int'(mon_dat), int'(vecs[i].rdat));
            end
        end

        // Abort: drop cyc while waiting on read data; the next request must be taken at once.
        tgt = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 11'h010; sel = 2'b11;
        @(posedge clk); #1;
        check("abort_rden", int'(a_rden), 1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        run_txn(1'b1, 11'h020, 2'b11, 16'h5555, 0, lat, we_n, we_v, rd_n, ack_n, err_n);
        check("abort_next_lat", lat,   2);
        check("abort_next_ack", ack_n, 1);
        check("abort_next_we",  int'(we_v), 3);
        run_txn(1'b0, 11'h020, 2'b11, 16'h0000, 0, lat, we_n, we_v, rd_n, ack_n, err_n);
        check("abort_rb_dat", int'(a_dat_o), 16'h5555);

        // Asynchronous reset in the middle of a read wait.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 11'h010; sel = 2'b11;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack",  int'(a_ack),   0);
        check("mid_rst_err",  int'(a_err),   0);
        check("mid_rst_dat",  int'(a_dat_o), 0);
        check("mid_rst_rden", int'(a_rden),  0);
        check("mid_rst_addr", int'(a_addr),  0);
        check("mid_rst_din",  int'(a_din),   0);
        check("mid_rst_we",   int'(a_we),    0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (a_ack || a_err) stray++;
        end
        check("post_rst_no_ack", stray, 0);
        run_txn(1'b0, 11'h010, 2'b11, 16'h0000, 0, lat, we_n, we_v, rd_n, ack_n, err_n);
        check("post_rst_lat", lat,   3);
        check("post_rst_ack", ack_n, 1);
        check("post_rst_dat", int'(a_dat_o), 16'h125A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
